bias_acc_relu_layer16: RTL and testbench
========================================

# bias_acc_relu_layer16

Layer-16 output stage that sits directly downstream of the per-layer bias constant bank and the convolution adder tree. It accumulates `N_PASS` consecutive partial-sum beats per output group, with `N_adder_tree` lanes per beat, and seeds each lane's accumulator with that lane's bias. It then saturates each lane to 18 bits, optionally applies ReLU, and holds the result vector in an output register behind a valid/ready handshake for the next layer's buffer.

## Interface
- `N_adder_tree`, 16: number of parallel lanes.
- `DATA_W`, 18: lane width of bias, partial sum and output; signed two's complement, same fixed-point format throughout.
- `ACC_W`, 24: internal accumulator width. Must satisfy ACC_W ≥ DATA_W + clog2(N_PASS+1); with this constraint no wrap is possible.
- `N_PASS`, 4: beats per output group, ≥ 1.
- `RELU`, 1: 1 clamps negative results to 0; 0 passes signed results.

Ports:
- `clk`, input, 1: single clock, rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `bias`, input, N_adder_tree*DATA_W: lane k is at bits [DATA_W*(k+1)-1 : DATA_W*k]; quasi-static, driven by the bias bank.
- `in_valid`, input, 1: partial-sum beat present.
- `in_ready`, output, 1: block can accept the beat.
- `in_data`, input, N_adder_tree*DATA_W: adder-tree partial sums, same lane packing as `bias`.
- `out_valid`, output, 1: output vector valid.
- `out_ready`, input, 1: consumer accepts the output.
- `out_data`, output, N_adder_tree*DATA_W: result vector, same lane packing.
- `group_cnt`, output, 16: number of groups delivered since reset; wraps modulo 2^16.

## Operation
- Beat accepted when in_valid && in_ready. Output accepted when out_valid && out_ready.
- `pass_cnt` counts 0..N_PASS-1 and increments on each accepted beat. It wraps to 0 after the last beat of a group.
- Per lane, on an accepted beat:
  - pass_cnt==0: acc_k ← sext(bias_k) + sext(in_k). Bias is sampled only on this beat.
  - otherwise: acc_k ← acc_k + sext(in_k).
- Last beat (pass_cnt==N_PASS-1) also writes the output register, computed combinationally from the same sum s = acc_k(+bias) + in_k:
  - sat = s > 2^(DATA_W-1)-1 ? 131071 : s < -2^(DATA_W-1) ? -131072 : s.
  - out_k = (RELU && sat<0) ? 0 : sat.
  - Saturation is applied before ReLU.
- N_PASS==1: every accepted beat is both first and last. out = sat(bias+in).
- Same edge as the last beat: set out_valid and increment group_cnt.
- in_ready = !(out_valid && !out_ready && pass_cnt==N_PASS-1).
  - Non-final beats of the next group are always accepted while the output is held.
  - Only the completing beat stalls.
- Simultaneous output accept and last-beat accept: out_data takes the new vector and out_valid stays 1.
- Output accepted with no new completion: out_valid ← 0. out_data holds its last value.
- out_data and out_valid are stable while out_valid && !out_ready.
- in_data is ignored when in_valid=0. in_data is also ignored when in_ready=0, and pass_cnt does not advance.

## Timing
- Reset (async assert, release synchronized externally): acc=0, pass_cnt=0, out_valid=0, out_data=0, group_cnt=0. in_ready=1 immediately after reset.
- Reset mid-group discards the partial accumulation. The next accepted beat is treated as pass 0.
- Latency: out_valid rises on the clock edge that accepts the last beat of a group, so it is visible the cycle after that beat was presented.
- Throughput: one beat per cycle. One group per N_PASS cycles when out_ready=1.
- No combinational path from in_valid to in_ready. in_ready depends only on registered state and out_ready.

## Test plan
- Basic accumulation: N_PASS=4, RELU=1, bias lane0=2256 and lane3=-9188, all lanes in=100 for 4 beats. Expect lane0=2656 and lane3=0; one out_valid pulse; group_cnt=1.
- RELU=0, same stimulus as basic accumulation: expect lane3=-8788 (0x3DDAC).
- Positive saturation: in lane0=131071 on all 4 beats, bias 2256. Expect lane0=131071. Negative saturation with RELU=0, in=-131072 ×4: expect -131072.
- Backpressure: out_ready=0 after group 1 completes, in_valid=1 continuously.
  - Next 3 beats are accepted and in_ready drops at pass 3.
  - out_data is unchanged while held.
  - Raising out_ready accepts group 1 and group 2 completes on that same edge; out_valid stays 1 and carries the group-2 values.
- Bias change mid-group: change bias after the pass-0 beat. The result must use the pass-0 bias; the next group uses the new bias.
- Reset mid-group: assert rst_n=0 after 2 beats. All outputs are 0 and group_cnt=0; then 4 fresh beats give the correct group with no residue from the discarded beats.

Source files
------------

// File: rtl/bias_acc_relu_layer16.sv
// bias_acc_relu_layer16: per-lane bias-seeded accumulation over N_PASS beats, then 18-bit saturation, optional ReLU and a held valid/ready output
// Ports: clk/rst_n (async active-low); bias, in_valid/in_ready/in_data (partial-sum beats);
//        out_valid/out_ready/out_data (result vector); group_cnt (groups delivered, wraps at 2^16)
module bias_acc_relu_layer16 #(
    parameter int N_adder_tree = 16,
    parameter int DATA_W       = 18,
    parameter int ACC_W        = 24,
    parameter int N_PASS       = 4,
    parameter int RELU         = 1
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [N_adder_tree*DATA_W-1:0] bias,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [N_adder_tree*DATA_W-1:0] in_data,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [N_adder_tree*DATA_W-1:0] out_data,
    output logic [15:0]                    group_cnt
);
    localparam int PW = N_PASS > 1 ? $clog2(N_PASS) : 1;
    localparam logic signed [ACC_W-1:0] MAXV = ACC_W'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] MINV = -MAXV - 1;
    logic [PW-1:0] pass_cnt;
    logic first, last, take;
    logic [N_adder_tree-1:0][ACC_W-1:0] acc, sum;
    logic [N_adder_tree-1:0][DATA_W-1:0] res;
    assign first = pass_cnt == '0;
    assign last = pass_cnt == PW'(N_PASS - 1);
    // only the completing beat has to wait for the held output to drain
    assign in_ready = !(out_valid && !out_ready && last);
    assign take = in_valid && in_ready;
    for (genvar k = 0; k < N_adder_tree; k++) begin : g_lane
        logic signed [ACC_W-1:0] b, d, s;
        logic [DATA_W-1:0] sat;
        assign b = ACC_W'($signed(bias[DATA_W*k +: DATA_W]));
        assign d = ACC_W'($signed(in_data[DATA_W*k +: DATA_W]));
        // bias seeds the lane only on the first beat of a group
        assign s = (first ? b : $signed(acc[k])) + d;
        assign sat = s > MAXV ? MAXV[DATA_W-1:0] : s < MINV ? MINV[DATA_W-1:0] : s[DATA_W-1:0];
        assign sum[k] = s;
        assign res[k] = (RELU != 0 && sat[DATA_W-1]) ? '0 : sat;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            pass_cnt  <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            group_cnt <= '0;
        end else begin
            if (take) begin
                acc      <= sum;
                pass_cnt <= last ? '0 : pass_cnt + 1'b1;
            end
            if (take && last) begin
                out_data  <= res;
                out_valid <= 1'b1;
                group_cnt <= group_cnt + 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_bias_acc_relu_layer16.sv
// tb_bias_acc_relu_layer16: scoreboard bench driving a ReLU and a linear instance with shared stimulus
module tb_bias_acc_relu_layer16;
    localparam int N = 16, W = 18, NP = 4, VW = N * W;
    logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
    logic [VW-1:0] bias = '0, in_data = '0;
    logic in_ready1, in_ready0, out_valid1, out_valid0;
    logic [VW-1:0] out1, out0;
    logic [15:0] gc1, gc0;
    int errors = 0, checks = 0;
    bit rnd = 1'b0;
    always #5 clk = ~clk;

    bias_acc_relu_layer16 #(.RELU(1)) u_relu (
        .clk(clk), .rst_n(rst_n), .bias(bias), .in_valid(in_valid), .in_ready(in_ready1),
        .in_data(in_data), .out_valid(out_valid1), .out_ready(out_ready), .out_data(out1), .group_cnt(gc1)
    );
    bias_acc_relu_layer16 #(.RELU(0)) u_lin (
        .clk(clk), .rst_n(rst_n), .bias(bias), .in_valid(in_valid), .in_ready(in_ready0),
        .in_data(in_data), .out_valid(out_valid0), .out_ready(out_ready), .out_data(out0), .group_cnt(gc0)
    );

    task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [VW-1:0] rep(input int v);
        logic [VW-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'(v);
        return r;
    endfunction

    function automatic logic [W-1:0] lane(input logic [VW-1:0] v, input int k);
        return v[k*W +: W];
    endfunction

    function automatic logic [VW-1:0] base_bias();
        logic [VW-1:0] r;
        for (int k = 0; k < N; k++) r[k*W +: W] = W'(k * 3000 - 20000);
        r[0 +: W] = W'(2256);
        r[3*W +: W] = W'(-9188);
        return r;
    endfunction

    // reference model and scoreboard, sampled mid-cycle after inputs settle
    int macc[N];
    int mpass = 0, mb, md, ms, msat;
    bit mov = 1'b0;
    logic [15:0] mgc = '0;
    logic [VW-1:0] q1[$], q0[$];
    logic [VW-1:0] e1, e0;
    logic exp_rdy;
    always begin
        @(negedge clk);
        #2;
        if (!rst_n) begin
            check("rst_ready", VW'(in_ready1), VW'(1));
            check("rst_valid", VW'(out_valid1), VW'(0));
            check("rst_data", out1 | out0, '0);
            check("rst_gcnt", VW'(gc1 | gc0), VW'(0));
            mpass = 0; mov = 1'b0; mgc = '0;
            q1.delete(); q0.delete();
            foreach (macc[k]) macc[k] = 0;
        end else begin
            exp_rdy = !(mov && !out_ready && mpass == NP - 1);
            check("in_ready_relu", VW'(in_ready1), VW'(exp_rdy));
            check("in_ready_lin", VW'(in_ready0), VW'(exp_rdy));
            check("out_valid_relu", VW'(out_valid1), VW'(mov));
            check("out_valid_lin", VW'(out_valid0), VW'(mov));
            check("group_cnt_relu", VW'(gc1), VW'(mgc));
            check("group_cnt_lin", VW'(gc0), VW'(mgc));
            if (mov) begin
                if (q1.size() == 0) check("sb_empty", VW'(0), VW'(1));
                else begin
                    check("out_data_relu", out1, q1[0]);
                    check("out_data_lin", out0, q0[0]);
                end
            end
            if (mov && out_ready) begin
                if (q1.size() != 0) begin
                    void'(q1.pop_front());
                    void'(q0.pop_front());
                end
                mov = 1'b0;
            end
            if (in_valid && exp_rdy) begin
                e1 = '0; e0 = '0;
                for (int k = 0; k < N; k++) begin
                    mb = int'($signed(bias[k*W +: W]));
                    md = int'($signed(in_data[k*W +: W]));
                    ms = (mpass == 0 ? mb : macc[k]) + md;
                    macc[k] = ms;
                    msat = ms > 131071 ? 131071 : ms < -131072 ? -131072 : ms;
                    e0[k*W +: W] = W'(msat);
                    e1[k*W +: W] = msat < 0 ? '0 : W'(msat);
                end
                if (mpass == NP - 1) begin
                    q1.push_back(e1);
                    q0.push_back(e0);
                    mov = 1'b1;
                    mgc++;
                    mpass = 0;
                end else mpass++;
            end
        end
    end

    task automatic beat(input logic [VW-1:0] b, input logic [VW-1:0] d);
        bit ok = 1'b0;
        for (int t = 0; t < 20 && !ok; t++) begin
            @(negedge clk);
            bias = b; in_data = d; in_valid = 1'b1;
            if (rnd) out_ready = (t > 2) || ($urandom_range(0, 1) == 1);
            #1 ok = in_ready1;
            @(posedge clk);
        end
        if (!ok) check("beat_timeout", VW'(0), VW'(1));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic group(input logic [VW-1:0] b, input logic [VW-1:0] d);
        repeat (NP) beat(b, d);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [VW-1:0] bb, d, rb;
        bb = base_bias();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        group(bb, rep(100));
        idle();
        #1;
        check("basic_l0", VW'(lane(out1, 0)), VW'(18'd2656));
        check("basic_l3_relu", VW'(lane(out1, 3)), VW'(0));
        check("basic_l3_lin", VW'(lane(out0, 3)), VW'(18'h3DDAC));
        check("basic_gcnt", VW'(gc1), VW'(1));
        idle();
        #1 check("basic_pulse", VW'(out_valid1), VW'(0));
        d = rep(100);
        d[0 +: W] = 18'h1FFFF;
        group(bb, d);
        idle();
        #1 check("pos_sat", VW'(lane(out1, 0)), VW'(18'h1FFFF));
        group(bb, rep(-131072));
        idle();
        #1;
        check("neg_sat_lin", VW'(lane(out0, 0)), VW'(18'h20000));
        check("neg_sat_relu", VW'(lane(out1, 0)), VW'(0));
        beat(bb, rep(100));
        repeat (3) beat(rep(5000), rep(100));
        idle();
        #1 check("bias_old", VW'(lane(out1, 0)), VW'(18'd2656));
        group(rep(5000), rep(100));
        idle();
        #1 check("bias_new", VW'(lane(out1, 0)), VW'(18'd5400));
        repeat (3) beat(bb, rep(100));
        out_ready = 1'b0;
        beat(bb, rep(100));
        repeat (3) beat(bb, rep(300));
        @(negedge clk);
        in_data = rep(300); in_valid = 1'b1;
        #1 check("bp_stall", VW'(in_ready1), VW'(0));
        check("bp_data", VW'(lane(out1, 0)), VW'(18'd2656));
        @(negedge clk);
        #1 check("bp_hold", VW'(lane(out1, 0)), VW'(18'd2656));
        check("bp_hold_valid", VW'(out_valid1), VW'(1));
        @(negedge clk);
        out_ready = 1'b1;
        #1 check("bp_release", VW'(in_ready1), VW'(1));
        idle();
        #1 check("bp_valid_kept", VW'(out_valid1), VW'(1));
        check("bp_group2", VW'(lane(out1, 0)), VW'(18'd3456));
        rnd = 1'b1;
        repeat (6) begin
            for (int k = 0; k < N; k++) rb[k*W +: W] = W'(int'($urandom_range(0, 80000)) - 40000);
            repeat (NP) begin
                for (int k = 0; k < N; k++) d[k*W +: W] = W'(int'($urandom_range(0, 80000)) - 40000);
                beat(rb, d);
                if ($urandom_range(0, 3) == 0) idle();
            end
        end
        rnd = 1'b0;
        out_ready = 1'b1;
        repeat (2) idle();
        repeat (2) beat(bb, rep(5000));
        @(negedge clk);
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1 check("mid_rst_valid", VW'(out_valid1), VW'(0));
        check("mid_rst_gcnt", VW'(gc1), VW'(0));
        check("mid_rst_data", out1, '0);
        @(negedge clk);
        rst_n = 1'b1;
        group(bb, rep(100));
        idle();
        #1 check("post_rst_l0", VW'(lane(out1, 0)), VW'(18'd2656));
        check("post_rst_gcnt", VW'(gc1), VW'(1));
        repeat (3) idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
